// File: rtl/db9_joy_serial_scan.sv
// DB9 joystick front end: either reflects the middleboard shifter signals or scans
// a 74HC165-style chain itself and presents a latched, polarity-corrected button vector.
module db9_joy_serial_scan #(
    parameter int unsigned NUM_CHANNELS = 2,
    parameter int unsigned BITS_PER_CH  = 12,
    parameter int unsigned CLK_DIV      = 8,
    parameter int unsigned FRAME_GAP    = 256,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic                                  CLK_50,
    input  logic                                  reset,
    input  logic                                  mode_passthru,
    input  logic                                  XJOY_CLK,
    input  logic                                  XJOY_LOAD,
    output logic                                  XJOY_DATA,
    output logic                                  JOY_CLK,
    output logic                                  JOY_LOAD,
    input  logic                                  JOY_DATA,
    output logic                                  JOY_SELECT,
    output logic [NUM_CHANNELS*BITS_PER_CH-1:0]   joy_out,
    output logic                                  joy_valid
);

    localparam int unsigned TOTAL = NUM_CHANNELS * BITS_PER_CH;
    localparam int unsigned PW    = $clog2(2 * CLK_DIV + 1);
    localparam int unsigned BW    = $clog2(TOTAL + 1);
    localparam int unsigned GW    = $clog2(FRAME_GAP + 1);
    localparam logic        INV   = (ACTIVE_LOW != 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_LATCH,
        ST_GAP
    } state_t;

    state_t             state_q, state_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [GW-1:0]      gap_q, gap_d;
    logic [TOTAL-1:0]   sr_q, sr_d;
    logic [TOTAL-1:0]   joy_out_d;
    logic               clk_q, clk_d;
    logic               load_q, load_d;
    logic               valid_d;
    logic               mode_q;
    logic               sample_c;

    // State, counters, shift register and registered pin drivers
    always_ff @(posedge CLK_50) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            phase_q   <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            sr_q      <= '0;
            clk_q     <= 1'b0;
            load_q    <= 1'b1;
            mode_q    <= 1'b0;
            joy_out   <= '0;
            joy_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
            sr_q      <= sr_d;
            clk_q     <= clk_d;
            load_q    <= load_d;
            mode_q    <= mode_passthru;
            joy_out   <= joy_out_d;
            joy_valid <= valid_d;
        end
    end

    // Next-state and next-output decode; pin levels follow the state being entered
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_d     = bit_q;
        gap_d     = gap_q;
        sr_d      = sr_q;
        joy_out_d = joy_out;
        sample_c  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
                phase_d = '0;
            end
            ST_LOAD: begin
                if (phase_q == PW'(2 * CLK_DIV - 1)) begin
                    state_d = ST_SHIFT;
                    phase_d = '0;
                    bit_d   = '0;
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_SHIFT: begin
                // Data is taken on the edge that ends the low phase, before the chain shifts
                sample_c = (phase_q == PW'(CLK_DIV - 1));
                if (phase_q == PW'(2 * CLK_DIV - 1)) begin
                    phase_d = '0;
                    if (bit_q == BW'(TOTAL - 1)) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end else begin
                    phase_d = phase_q + PW'(1);
                end
            end
            ST_LATCH: begin
                state_d = ST_GAP;
                gap_d   = '0;
            end
            ST_GAP: begin
                if (gap_q == GW'(FRAME_GAP - 1)) begin
                    state_d = ST_LOAD;
                    phase_d = '0;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Pass-through parks the scanner and drops any partial frame
        if (mode_q) begin
            state_d  = ST_IDLE;
            sample_c = 1'b0;
        end

        for (int unsigned i = 0; i < TOTAL; i++) begin
            if (sample_c && (bit_q == BW'(TOTAL - 1 - i))) begin
                sr_d[i] = JOY_DATA ^ INV;
            end
        end

        if (state_d == ST_LATCH) begin
            joy_out_d = sr_q;
        end

        clk_d   = (state_d == ST_SHIFT) && (phase_d >= PW'(CLK_DIV));
        load_d  = (state_d != ST_LOAD);
        valid_d = (state_d == ST_LATCH);
    end

    assign JOY_CLK    = mode_q ? XJOY_CLK  : clk_q;
    assign JOY_LOAD   = mode_q ? XJOY_LOAD : load_q;
    assign XJOY_DATA  = mode_q ? JOY_DATA  : 1'b1;
    assign JOY_SELECT = 1'b1;

endmodule
